meas_uart_report: RTL and testbench
===================================

Name: meas_uart_report

Overview:
- Downstream consumer of the phase/frequency measurement stage.
- Periodically snapshots the 32-bit frequency count and 32-bit phase result.
- Converts both to 10-digit decimal ASCII and transmits a fixed text frame over a UART 8N1 line for the host/display MCU.
- Sits between the measurement core and the board UART TX pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate. Bit divider = CLK_FREQ/BAUD, truncated; 434 at the defaults.
- PERIOD_CYCLES, 50_000_000, clk cycles between automatic report ticks (1 s at the default clock).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- freq_in  in  32  frequency count from the measurement stage, unsigned binary.
- phase_in  in  32  phase result from the measurement stage, unsigned binary.
- report_req  in  1  single-cycle pulse requesting an immediate report.
- uart_tx  out  1  serial output; idle high.
- busy  out  1  high from snapshot until the last stop bit has completed.
- frame_done  out  1  one-cycle pulse when the last stop bit ends.
- req_drop  out  1  one-cycle pulse when a tick or report_req is ignored because busy=1.

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: uart_tx=1, busy=0, frame_done=0, req_drop=0; period counter=0; FSM in IDLE.
- Period timer:
  - Free-running 0..PERIOD_CYCLES-1; generates a tick at wrap.
  - Keeps running while busy.
  - A trigger is tick OR report_req; a simultaneous tick and report_req counts as one trigger.
- Frame format: 27 bytes, ASCII: "F=" + 10 freq digits + " P=" + 10 phase digits + CR (0x0D) + LF (0x0A).
  - Digits are MSD first.
  - Leading zeros are kept.
- FSM states:
  - IDLE: on trigger, go to LATCH. busy rises in the cycle after the trigger.
  - LATCH: copy freq_in and phase_in into snapshot registers in the same cycle; go to CONV_F. Later input changes do not affect the frame.
  - CONV_F: sequential double-dabble, 32 shift iterations, one per clk. Before each shift, add 3 to every BCD nibble that is >=5. Produces 40-bit BCD. Then go to CONV_P.
  - CONV_P: same conversion for phase; then go to SEND_LOAD.
  - SEND_LOAD: select byte[idx] (idx 0..26) and start the UART transmitter; go to SEND_WAIT.
  - SEND_WAIT: on transmitter done, idx+1. If idx was 26, go to DONE; else go to SEND_LOAD.
  - DONE: pulse frame_done, clear busy, return to IDLE.
- UART transmitter:
  - Sends a start bit (0), data bits 0..7 LSB first, then a stop bit (1).
  - Each bit is held exactly CLK_FREQ/BAUD cycles.
  - The next start bit may begin the cycle after the stop bit ends; no idle gap is required.
- Any trigger while busy=1 is ignored and pulses req_drop; no queuing.
- Maximum value 4294967295 converts exactly; 10 digits is sufficient for 32 bits.
- Reset mid-frame: uart_tx returns high asynchronously, the frame is abandoned, and nothing resumes after release.

Optional Feature:
- Macro: REPORT_CKSUM_EN.
- When defined:
  - Insert "*" plus two uppercase hex ASCII digits before CR LF; the frame becomes 30 bytes.
  - The checksum is the XOR of all bytes from 'F' through the last phase digit inclusive.
- When undefined: the frame is 27 bytes exactly as described above, with no checksum logic.

Test Plan:
- freq_in=1000, phase_in=900, report_req pulse -> uart_tx carries "F=0000001000 P=0000000900\r\n" (27 bytes); frame_done pulses once; busy low afterward.
- freq_in=32'hFFFF_FFFF, phase_in=0 -> frame "F=4294967295 P=0000000000\r\n".
- Defaults, single byte -> every bit width measures 434 clk; start bit low, stop bit high, LSB first; total 27*10*434 = 117180 cycles from first start bit to the end of the last stop bit.
- Change freq_in/phase_in every cycle after the trigger -> frame reflects the values present in the LATCH cycle only. A report_req pulse during the frame -> req_drop pulses, with no extra frame.
- Assert rst_n low at byte 10, bit 4 -> uart_tx=1 immediately and busy=0. After release, no output until the next trigger, which then produces a full fresh frame.
- REPORT_CKSUM_EN defined, freq_in=0, phase_in=0 -> frame "F=0000000000 P=0000000000*36\r\n" (30 bytes).

Source files
------------

// File: rtl/meas_uart_report.sv
// meas_uart_report: snapshots the frequency/phase measurement pair on a
// periodic tick or on request, converts both to 10-digit decimal ASCII and
// sends "F=dddddddddd P=dddddddddd\r\n" over a UART 8N1 line.
// Optional build macro REPORT_CKSUM_EN inserts "*HH" (XOR checksum of the
// 'F' through the last phase digit, uppercase hex) before CR LF.
// The bit divider CLK_FREQ/BAUD must be at least 2.
module meas_uart_report #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned PERIOD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] freq_in,
  input  logic [31:0] phase_in,
  input  logic        report_req,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done,
  output logic        req_drop
);

  localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
  localparam int unsigned DW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned PW      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
`ifdef REPORT_CKSUM_EN
  localparam int unsigned FRAME_LEN = 30;
`else
  localparam int unsigned FRAME_LEN = 27;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CONV_F, S_CONV_P, S_SEND_LOAD, S_SEND_WAIT, S_DONE
  } state_t;

  state_t state, state_next;

  logic [PW-1:0] per_cnt;
  logic          tick_c, trigger_c;

  logic [4:0]  conv_cnt;
  logic [31:0] bin_sh;
  logic [31:0] snap_p;
  logic [39:0] work_bcd;
  logic [39:0] bcd_f;
  logic [39:0] adj_c;
  logic [4:0]  idx;
  logic [7:0]  byte_c;

  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [DW-1:0] tx_baud;
  logic          tx_active;
  logic          tx_next_c;

  logic latch_c, conv_c, conv_swap_c, tx_start_c, idx_inc_c, frame_end_c;

  // Adds 3 to every BCD nibble >= 5 ahead of the double-dabble shift.
  function automatic logic [39:0] dd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef REPORT_CKSUM_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'(8'h37 + {4'h0, n});
  endfunction
`endif

  assign tick_c    = (per_cnt == PW'(PERIOD_CYCLES - 1));
  assign trigger_c = tick_c | report_req;
  assign adj_c     = dd_adjust(work_bcd);
  // High in the second-to-last cycle of a stop bit so the next start bit
  // can follow with no idle gap.
  assign tx_next_c = tx_active && (tx_bit == 4'd9) && (tx_baud == DW'(BIT_DIV - 2));

  // Free-running report period counter; keeps counting through frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      per_cnt <= '0;
    else if (tick_c) per_cnt <= '0;
    else             per_cnt <= per_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (trigger_c) state_next = S_LATCH;
      S_LATCH:     state_next = S_CONV_F;
      S_CONV_F:    if (conv_cnt == 5'd31) state_next = S_CONV_P;
      S_CONV_P:    if (conv_cnt == 5'd31) state_next = S_SEND_LOAD;
      S_SEND_LOAD: state_next = S_SEND_WAIT;
      S_SEND_WAIT: if (tx_next_c) begin
                     state_next = (idx == 5'(FRAME_LEN - 1)) ? S_DONE : S_SEND_LOAD;
                   end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // FSM control strobes for the datapath.
  always_comb begin
    latch_c     = 1'b0;
    conv_c      = 1'b0;
    conv_swap_c = 1'b0;
    tx_start_c  = 1'b0;
    idx_inc_c   = 1'b0;
    frame_end_c = 1'b0;
    case (state)
      S_LATCH:     latch_c = 1'b1;
      S_CONV_F:    begin
                     conv_c      = 1'b1;
                     conv_swap_c = (conv_cnt == 5'd31);
                   end
      S_CONV_P:    conv_c = 1'b1;
      S_SEND_LOAD: tx_start_c = 1'b1;
      S_SEND_WAIT: if (tx_next_c) begin
                     idx_inc_c   = 1'b1;
                     frame_end_c = (idx == 5'(FRAME_LEN - 1));
                   end
      default:     ;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      req_drop   <= 1'b0;
    end else begin
      busy       <= (state_next != S_IDLE);
      frame_done <= frame_end_c;
      req_drop   <= trigger_c && (state != S_IDLE);
    end
  end

  // Snapshot plus sequential double-dabble; frequency first, then phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sh   <= '0;
      snap_p   <= '0;
      work_bcd <= '0;
      bcd_f    <= '0;
      conv_cnt <= '0;
    end else if (latch_c) begin
      bin_sh   <= freq_in;
      snap_p   <= phase_in;
      work_bcd <= '0;
      conv_cnt <= '0;
    end else if (conv_swap_c) begin
      bcd_f    <= {adj_c[38:0], bin_sh[31]};
      work_bcd <= '0;
      bin_sh   <= snap_p;
      conv_cnt <= '0;
    end else if (conv_c) begin
      work_bcd <= {adj_c[38:0], bin_sh[31]};
      bin_sh   <= {bin_sh[30:0], 1'b0};
      conv_cnt <= conv_cnt + 1'b1;
    end
  end

  // Byte index within the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         idx <= '0;
    else if (latch_c)   idx <= '0;
    else if (idx_inc_c) idx <= idx + 1'b1;
  end

  // Frame byte selected by idx; work_bcd holds the phase digits after conversion.
  always_comb begin
    logic [5:0] fsh;
    logic [5:0] psh;
    logic [3:0] digit_f;
    logic [3:0] digit_p;
`ifdef REPORT_CKSUM_EN
    logic [3:0] nib_xor;
    logic [7:0] cks;
    nib_xor = 4'h0;
    for (int i = 0; i < 10; i++) nib_xor = nib_xor ^ bcd_f[4*i +: 4] ^ work_bcd[4*i +: 4];
    // "F= P=" XOR to 0x36; the twenty 0x3 high nibbles cancel out.
    cks = 8'h36 ^ {4'h0, nib_xor};
`endif
    fsh     = 6'(6'(5'd11 - idx) * 6'd4);
    psh     = 6'(6'(5'd24 - idx) * 6'd4);
    digit_f = 4'(bcd_f >> fsh);
    digit_p = 4'(work_bcd >> psh);
    byte_c  = 8'h0A;
    if      (idx == 5'd0)  byte_c = 8'h46;
    else if (idx == 5'd1)  byte_c = 8'h3D;
    else if (idx <= 5'd11) byte_c = {4'h3, digit_f};
    else if (idx == 5'd12) byte_c = 8'h20;
    else if (idx == 5'd13) byte_c = 8'h50;
    else if (idx == 5'd14) byte_c = 8'h3D;
    else if (idx <= 5'd24) byte_c = {4'h3, digit_p};
`ifdef REPORT_CKSUM_EN
    else if (idx == 5'd25) byte_c = 8'h2A;
    else if (idx == 5'd26) byte_c = hex_ascii(cks[7:4]);
    else if (idx == 5'd27) byte_c = hex_ascii(cks[3:0]);
    else if (idx == 5'd28) byte_c = 8'h0D;
`else
    else if (idx == 5'd25) byte_c = 8'h0D;
`endif
    else                   byte_c = 8'h0A;
  end

  // UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx   <= 1'b1;
      tx_active <= 1'b0;
      tx_sh     <= '1;
      tx_bit    <= '0;
      tx_baud   <= '0;
    end else if (tx_start_c) begin
      uart_tx   <= 1'b0;
      tx_sh     <= {1'b1, byte_c};
      tx_bit    <= '0;
      tx_baud   <= '0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (tx_baud == DW'(BIT_DIV - 1)) begin
        tx_baud <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
          uart_tx   <= 1'b1;
        end else begin
          tx_bit  <= tx_bit + 1'b1;
          uart_tx <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meas_uart_report.sv
// Directed bench for meas_uart_report with a short bit divider and period.
module tb_meas_uart_report;

  localparam int unsigned CLK_FREQ = 1_050_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DIV      = 10;      // 1_050_000 / 100_000 truncated
  localparam int unsigned PERIOD   = 20_000;
`ifdef REPORT_CKSUM_EN
  localparam int FLEN = 30;
`else
  localparam int FLEN = 27;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] freq_in;
  logic [31:0] phase_in;
  logic        report_req;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic        req_drop;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int fd_count = 0;
  int fd_cyc   = 0;
  int drop_count = 0;
  logic [7:0] exp_fr [0:29];

  meas_uart_report #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PERIOD_CYCLES(PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freq_in(freq_in), .phase_in(phase_in),
    .report_req(report_req), .uart_tx(uart_tx), .busy(busy),
    .frame_done(frame_done), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_count <= fd_count + 1;
      fd_cyc   <= cyc;
    end
    if (req_drop) drop_count <= drop_count + 1;
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  // Expected frame from the hand-written 25-character body.
  task automatic set_expect(input string body);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 30; i++) exp_fr[i] = 8'h00;
    for (int i = 0; i < 25; i++) begin
      exp_fr[i] = body[i];
      x = x ^ body[i];
    end
`ifdef REPORT_CKSUM_EN
    exp_fr[25] = 8'h2A;
    exp_fr[26] = hexc(x[7:4]);
    exp_fr[27] = hexc(x[3:0]);
    exp_fr[28] = 8'h0D;
    exp_fr[29] = 8'h0A;
`else
    exp_fr[25] = 8'h0D;
    exp_fr[26] = 8'h0A;
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    @(posedge clk); #1;
    report_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise: busy=%b required 1 the cycle after the trigger", busy);
    end
  endtask

  // Checks every cycle of every bit against exp_fr; optional request pulse
  // at drop_at byte start, optional reset at byte rst_at bit 4.
  task automatic rx_frame(input int drop_at, input int rst_at);
    int k0, fd0;
    bit ok, terr;
    logic [7:0] got;
    logic [9:0] bits;
    fd0 = fd_count;
    ok  = 1'b0;
    for (int w = 0; w < 300; w++) begin
      @(posedge clk); #1;
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL start_bit: uart_tx=%b, required 0 within 300 cycles", uart_tx);
      return;
    end
    k0 = cyc;
    for (int b = 0; b < FLEN; b++) begin
      bits = {1'b1, exp_fr[b], 1'b0};
      got  = 8'h00;
      terr = 1'b0;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < int'(DIV); c++) begin
          report_req = (b == drop_at && i == 0 && c == 0);
          if (b == rst_at && i == 4 && c == 0) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (uart_tx !== 1'b1 || busy !== 1'b0) begin
              failures++;
              $display("FAIL reset_mid: uart_tx=%b busy=%b required 1 and 0", uart_tx, busy);
            end
            return;
          end
          if (uart_tx !== bits[i]) terr = 1'b1;
          if (c == int'(DIV / 2) && i >= 1 && i <= 8) got[i-1] = uart_tx;
          @(posedge clk); #1;
        end
      end
      checks++;
      if (terr || got !== exp_fr[b]) begin
        failures++;
        $display("FAIL byte_%0d: got %h required %h (bit timing error=%0d)", b, got, exp_fr[b], terr);
      end
    end
    report_req = 1'b0;
    checks++;
    if (fd_count != fd0 + 1 || fd_cyc != k0 + FLEN * 10 * int'(DIV) - 1) begin
      failures++;
      $display("FAIL frame_done: pulses=%0d at cycle offset %0d, required 1 at %0d",
               fd_count - fd0, fd_cyc - k0, FLEN * 10 * int'(DIV) - 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_end: busy=%b required 0 after frame", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks += 4;
    if (uart_tx !== 1'b1)    begin failures++; $display("FAIL rst_uart_tx: %b required 1", uart_tx); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy: %b required 0", busy); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done: %b required 0", frame_done); end
    if (req_drop !== 1'b0)   begin failures++; $display("FAIL rst_req_drop: %b required 0", req_drop); end
  endtask

  task automatic test_basic();
    apply_reset();
    freq_in = 32'd1000; phase_in = 32'd900;
    set_expect("F=0000001000 P=0000000900");
    pulse_req();
    rx_frame(-1, -1);
  endtask

  task automatic test_max();
    apply_reset();
    freq_in = 32'hFFFF_FFFF; phase_in = 32'd0;
    set_expect("F=4294967295 P=0000000000");
    pulse_req();
    rx_frame(-1, -1);
  endtask

  task automatic test_zero();
    apply_reset();
    freq_in = 32'd0; phase_in = 32'd0;
    set_expect("F=0000000000 P=0000000000");
    pulse_req();
    rx_frame(-1, -1);
  endtask

  task automatic test_latch_and_drop();
    int d0;
    bit bad;
    apply_reset();
    freq_in = 32'd5; phase_in = 32'd6;
    set_expect("F=0123456789 P=4000000000");
    d0 = drop_count;
    pulse_req();
    freq_in = 32'd123456789; phase_in = 32'd4000000000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      freq_in  = $urandom;
      phase_in = $urandom;
    end
    rx_frame(5, -1);
    checks++;
    if (drop_count != d0 + 1) begin
      failures++;
      $display("FAIL req_drop: pulses=%0d required 1", drop_count - d0);
    end
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL no_extra_frame: activity=%0d required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    apply_reset();
    freq_in = 32'd55555; phase_in = 32'd31;
    set_expect("F=0000055555 P=0000000031");
    pulse_req();
    rx_frame(-1, 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL resume_after_reset: activity=%0d required 0", bad);
    end
    freq_in = 32'd42; phase_in = 32'd7;
    set_expect("F=0000000042 P=0000000007");
    pulse_req();
    rx_frame(-1, -1);
  endtask

  task automatic test_tick();
    apply_reset();
    freq_in = 32'd77; phase_in = 32'd88;
    set_expect("F=0000000077 P=0000000088");
    repeat (100) @(posedge clk);
    #1;
    pulse_req();
    rx_frame(-1, -1);
    while (cyc < rel_cyc + int'(PERIOD) - 1) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL tick_early: busy=%b required 0 before the period wrap", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL tick_start: busy=%b required 1 at cycle %0d after reset", busy, PERIOD);
    end
    rx_frame(-1, -1);
  endtask

  initial begin
    rst_n      = 1'b0;
    report_req = 1'b0;
    freq_in    = '0;
    phase_in   = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_latch_and_drop();
    test_reset_mid();
    test_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
